// File: rtl/multicycle_seq.sv
// Multi-cycle RV32I instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control,
// memory request handshakes with timeout, and retired-instruction counting.
module multicycle_seq #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             imm_data,
    output logic [1:0]       opcode_alu,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             bus_err,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [4:0] C_LOAD   = 5'b00000;
    localparam logic [4:0] C_OP_IMM = 5'b00100;
    localparam logic [4:0] C_STORE  = 5'b01000;
    localparam logic [4:0] C_OP     = 5'b01100;
    localparam logic [4:0] C_LUI    = 5'b01101;
    localparam logic [4:0] C_BRANCH = 5'b11000;
    localparam logic [4:0] C_JAL    = 5'b11011;

    localparam logic [1:0] ALU_BRANCH = 2'b00;
    localparam logic [1:0] ALU_OP_IMM = 2'b01;
    localparam logic [1:0] ALU_ADD    = 2'b10;
    localparam logic [1:0] ALU_OP     = 2'b11;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // The timeout fires on the last permitted wait cycle, so a ready that
    // arrives in that same cycle still completes the handshake.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [4:0] cls;
    logic [7:0] wait_cnt;
    logic       halt_pend;
    logic       retire;
    logic       timeout;
    logic       waiting;
    logic       legal;
    logic [1:0] alu_sel;
    logic       imm_sel;
    logic       unused_opcode_bits;

    assign unused_opcode_bits = ^opcode[1:0];

    always_comb begin
        legal = 1'b0;
        case (opcode[6:2])
            C_LOAD, C_OP_IMM, C_STORE, C_OP,
            C_LUI, C_BRANCH, C_JAL: legal = 1'b1;
            default:                legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_sel = ALU_ADD;
        imm_sel = 1'b1;
        case (cls)
            C_OP: begin
                alu_sel = ALU_OP;
                imm_sel = 1'b0;
            end
            C_OP_IMM, C_LUI: begin
                alu_sel = ALU_OP_IMM;
                imm_sel = 1'b1;
            end
            C_BRANCH: begin
                alu_sel = ALU_BRANCH;
                imm_sel = 1'b0;
            end
            default: begin
                alu_sel = ALU_ADD;
                imm_sel = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        reg_write  = 1'b0;
        imm_data   = 1'b0;
        opcode_alu = 2'b00;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        retire     = 1'b0;
        timeout    = 1'b0;
        waiting    = 1'b0;

        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
            end

            // A zero wait count marks the entry cycle, the only point a halt may cut in.
            S_FETCH: begin
                if (wait_cnt == 8'd0 && (halt_req || halt_pend)) begin
                    state_next = S_HALT;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write   = 1'b1;
                        state_next = S_DECODE;
                    end else begin
                        waiting = 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            timeout    = 1'b1;
                            state_next = S_HALT;
                        end
                    end
                end
            end

            S_DECODE: begin
                if (legal) begin
                    state_next = S_EXEC;
                end else begin
                    illegal    = 1'b1;
                    pc_write   = 1'b1;
                    pc_src     = PC_PLUS4;
                    state_next = S_FETCH;
                end
            end

            S_EXEC: begin
                opcode_alu = alu_sel;
                imm_data   = imm_sel;
                case (cls)
                    C_BRANCH: begin
                        pc_write   = 1'b1;
                        pc_src     = branch_taken ? PC_BRANCH : PC_PLUS4;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_next = S_MEM;
                    default:         state_next = S_WB;
                endcase
            end

            S_MEM: begin
                opcode_alu = alu_sel;
                imm_data   = imm_sel;
                dmem_req   = 1'b1;
                dmem_we    = (cls == C_STORE);
                if (dmem_ready) begin
                    if (cls == C_STORE) begin
                        pc_write   = 1'b1;
                        pc_src     = PC_PLUS4;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else begin
                    waiting = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        timeout    = 1'b1;
                        state_next = S_HALT;
                    end
                end
            end

            S_WB: begin
                opcode_alu = alu_sel;
                imm_data   = imm_sel;
                reg_write  = 1'b1;
                mem_to_reg = (cls == C_LOAD);
                pc_write   = 1'b1;
                pc_src     = (cls == C_JAL) ? PC_JUMP : PC_PLUS4;
                retire     = 1'b1;
                state_next = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
                if (!bus_err && !halt_req) begin
                    state_next = S_FETCH;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls <= 5'd0;
        end else if (state == S_DECODE) begin
            cls <= opcode[6:2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (state_next != state) begin
            wait_cnt <= 8'd0;
        end else if (waiting) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Halt requests seen mid-instruction are remembered until the next fetch entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_pend <= 1'b0;
        end else if (state == S_HALT) begin
            halt_pend <= 1'b0;
        end else if (halt_req && state != S_FETCH) begin
            halt_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err <= 1'b0;
        end else if (timeout) begin
            bus_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed self-checking bench for multicycle_seq: per-instruction-class
// sequences, halt handling, illegal opcodes, reset abort and memory timeouts.
module tb_multicycle_seq;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_ready;
    logic        halt_req;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic        imm_data;
    logic [1:0]  opcode_alu;
    logic        mem_to_reg;
    logic        illegal;
    logic        bus_err;
    logic        halted;
    logic [31:0] instret;

    int checks = 0;
    int passes = 0;

    multicycle_seq #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .halt_req     (halt_req),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .imm_data     (imm_data),
        .opcode_alu   (opcode_alu),
        .mem_to_reg   (mem_to_reg),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .halted       (halted),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        opcode       = 7'b0110011;
        branch_taken = 1'b0;
        imem_ready   = 1'b1;
        dmem_ready   = 1'b0;
        halt_req     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if ({imem_req, dmem_req, ir_write, pc_write, reg_write, halted, bus_err, illegal} !== 8'h00) $display("FAIL reset_outputs: got %b want 00000000", {imem_req, dmem_req, ir_write, pc_write, reg_write, halted, bus_err, illegal}); else passes++;
        checks++; if (instret !== 32'd0) $display("FAIL reset_instret: got %0d want 0", instret); else passes++;
        do_reset();
        checks++; if ({imem_req, ir_write, opcode_alu, pc_src} !== 6'b0) $display("FAIL idle_outputs: got %b want 000000", {imem_req, ir_write, opcode_alu, pc_src}); else passes++;
    endtask

    task automatic test_op();
        opcode = 7'b0110011;
        step();
        checks++; if ({imem_req, ir_write} !== 2'b11) $display("FAIL op_fetch: got %b want 11", {imem_req, ir_write}); else passes++;
        step();
        checks++; if ({illegal, pc_write, ir_write} !== 3'b000) $display("FAIL op_decode: got %b want 000", {illegal, pc_write, ir_write}); else passes++;
        step();
        checks++; if ({opcode_alu, imm_data, pc_write} !== 4'b1100) $display("FAIL op_exec: got %b want 1100", {opcode_alu, imm_data, pc_write}); else passes++;
        step();
        checks++; if ({reg_write, pc_write, pc_src, mem_to_reg, opcode_alu} !== 7'b1100011) $display("FAIL op_wb: got %b want 1100011", {reg_write, pc_write, pc_src, mem_to_reg, opcode_alu}); else passes++;
        step();
        checks++; if (instret !== 32'd1) $display("FAIL op_instret: got %0d want 1", instret); else passes++;
        checks++; if (ir_write !== 1'b1) $display("FAIL op_refetch: got %b want 1", ir_write); else passes++;
    endtask

    task automatic test_load();
        int req_cycles;
        opcode     = 7'b0000011;
        dmem_ready = 1'b0;
        step();
        step();
        checks++; if ({opcode_alu, imm_data} !== 3'b101) $display("FAIL load_exec: got %b want 101", {opcode_alu, imm_data}); else passes++;
        step();
        req_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (dmem_req === 1'b1 && dmem_we === 1'b0) req_cycles++;
            step();
        end
        if (dmem_req === 1'b1 && dmem_we === 1'b0) req_cycles++;
        dmem_ready = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b0) $display("FAIL load_mem_pc: got %b want 0", pc_write); else passes++;
        step();
        dmem_ready = 1'b0;
        checks++; if (req_cycles !== 4) $display("FAIL load_req_cycles: got %0d want 4", req_cycles); else passes++;
        checks++; if ({dmem_req, reg_write, mem_to_reg, pc_write, pc_src} !== 6'b011100) $display("FAIL load_wb: got %b want 011100", {dmem_req, reg_write, mem_to_reg, pc_write, pc_src}); else passes++;
        step();
        checks++; if ({instret, ir_write} !== {32'd2, 1'b1}) $display("FAIL load_retire: got instret %0d ir_write %b want 2 1", instret, ir_write); else passes++;
    endtask

    task automatic test_branch();
        opcode       = 7'b1100011;
        branch_taken = 1'b1;
        step();
        step();
        checks++; if ({pc_write, pc_src, reg_write, opcode_alu, imm_data} !== 7'b1010000) $display("FAIL branch_taken_exec: got %b want 1010000", {pc_write, pc_src, reg_write, opcode_alu, imm_data}); else passes++;
        step();
        checks++; if ({instret, ir_write, reg_write} !== {32'd3, 2'b10}) $display("FAIL branch_taken_retire: got %0d %b %b want 3 1 0", instret, ir_write, reg_write); else passes++;
        branch_taken = 1'b0;
        step();
        step();
        checks++; if ({pc_write, pc_src, reg_write} !== 4'b1000) $display("FAIL branch_not_taken_exec: got %b want 1000", {pc_write, pc_src, reg_write}); else passes++;
        step();
        checks++; if ({instret, ir_write} !== {32'd4, 1'b1}) $display("FAIL branch_not_taken_retire: got %0d %b want 4 1", instret, ir_write); else passes++;
    endtask

    task automatic test_jal_lui();
        opcode = 7'b1101111;
        step();
        step();
        checks++; if ({opcode_alu, imm_data} !== 3'b101) $display("FAIL jal_exec: got %b want 101", {opcode_alu, imm_data}); else passes++;
        step();
        checks++; if ({reg_write, pc_write, pc_src} !== 4'b1110) $display("FAIL jal_wb: got %b want 1110", {reg_write, pc_write, pc_src}); else passes++;
        step();
        opcode = 7'b0110111;
        step();
        step();
        checks++; if ({opcode_alu, imm_data} !== 3'b011) $display("FAIL lui_exec: got %b want 011", {opcode_alu, imm_data}); else passes++;
        step();
        checks++; if ({reg_write, pc_src} !== 3'b100) $display("FAIL lui_wb: got %b want 100", {reg_write, pc_src}); else passes++;
        step();
        checks++; if (instret !== 32'd6) $display("FAIL jal_lui_instret: got %0d want 6", instret); else passes++;
    endtask

    task automatic test_illegal();
        opcode = 7'b1111111;
        step();
        checks++; if ({illegal, pc_write, pc_src} !== 4'b1100) $display("FAIL illegal_decode: got %b want 1100", {illegal, pc_write, pc_src}); else passes++;
        step();
        checks++; if ({illegal, ir_write} !== 2'b01) $display("FAIL illegal_pulse: got %b want 01", {illegal, ir_write}); else passes++;
        checks++; if (instret !== 32'd6) $display("FAIL illegal_instret: got %0d want 6", instret); else passes++;
    endtask

    task automatic test_store_halt();
        opcode     = 7'b0100011;
        dmem_ready = 1'b1;
        step();
        step();
        halt_req = 1'b1;
        step();
        checks++; if ({dmem_req, dmem_we, pc_write, pc_src} !== 5'b11100) $display("FAIL store_mem: got %b want 11100", {dmem_req, dmem_we, pc_write, pc_src}); else passes++;
        step();
        checks++; if ({imem_req, instret} !== {1'b0, 32'd7}) $display("FAIL store_halt_entry: got %b %0d want 0 7", imem_req, instret); else passes++;
        step();
        step();
        checks++; if ({halted, imem_req} !== 2'b10) $display("FAIL halt_hold: got %b want 10", {halted, imem_req}); else passes++;
        halt_req   = 1'b0;
        dmem_ready = 1'b0;
        step();
        checks++; if ({halted, imem_req, ir_write} !== 3'b011) $display("FAIL halt_resume: got %b want 011", {halted, imem_req, ir_write}); else passes++;
        step();
        step();
        step();
        checks++; if ({dmem_req, dmem_we} !== 2'b11) $display("FAIL store_wait: got %b want 11", {dmem_req, dmem_we}); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if ({dmem_req, dmem_we, instret} !== {2'b00, 32'd0}) $display("FAIL reset_abort: got %b %b %0d want 0 0 0", dmem_req, dmem_we, instret); else passes++;
    endtask

    task automatic test_timeout_edge();
        do_reset();
        imem_ready = 1'b0;
        step();
        repeat (15) step();
        imem_ready = 1'b1;
        #1;
        checks++; if ({imem_req, ir_write} !== 2'b11) $display("FAIL timeout_edge_ready: got %b want 11", {imem_req, ir_write}); else passes++;
        step();
        checks++; if ({bus_err, halted} !== 2'b00) $display("FAIL timeout_edge_ok: got %b want 00", {bus_err, halted}); else passes++;
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        imem_ready = 1'b0;
        step();
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        checks++; if (n !== 16) $display("FAIL timeout_cycles: got %0d want 16", n); else passes++;
        checks++; if ({bus_err, halted, imem_req} !== 3'b110) $display("FAIL timeout_halt: got %b want 110", {bus_err, halted, imem_req}); else passes++;
        imem_ready = 1'b1;
        repeat (5) step();
        checks++; if ({bus_err, halted, imem_req} !== 3'b110) $display("FAIL timeout_sticky: got %b want 110", {bus_err, halted, imem_req}); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if ({bus_err, halted} !== 2'b00) $display("FAIL timeout_reset: got %b want 00", {bus_err, halted}); else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        test_reset();
        test_op();
        test_load();
        test_branch();
        test_jal_lui();
        test_illegal();
        test_store_halt();
        test_timeout_edge();
        test_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_seq.md
Name: multicycle_seq

Overview:
- Multi-cycle instruction sequencer for the RV32I core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- It drives instruction and data memory request handshakes, and one-cycle write enables for IR, PC and register file.
- It drives the ALU op class and the operand and writeback mux selects.
- Sits between the memory interfaces and the existing datapath; replaces single-cycle enable generation.

Parameters:
- TIMEOUT, 16, max cycles waiting on imem_ready/dmem_ready before bus error (1..255).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction[6:0] from IR (valid from DECODE onward)
- branch_taken  in  1  comparator result from datapath, sampled in EXEC
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- halt_req  in  1  debug halt request
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- ir_write  out  1  load IR
- pc_write  out  1  update PC
- pc_src  out  2  00 pc+4, 01 branch target, 10 jump target
- reg_write  out  1  register file write enable
- imm_data  out  1  ALU operand B = immediate
- opcode_alu  out  2  01 op_imm, 11 op, 00 branch compare, 10 add (address/default)
- mem_to_reg  out  1  writeback from load data
- illegal  out  1  one-cycle pulse, unsupported opcode
- bus_err  out  1  sticky, memory timeout
- halted  out  1  high in HALT
- instret  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset forces IDLE, instret=0, bus_err=0, and the latched opcode class to 0. All outputs are 0 in IDLE.
- Reset mid-operation aborts any request immediately, with no handshake completion.
- IDLE -> FETCH unconditionally on the next clk.
- Outputs are combinational decodes of the registered state plus the opcode class latched in DECODE (opcode[6:2]). There are no output flops except instret and bus_err.
- FETCH:
  - If halt_req=1 on entry cycle (before imem_req is asserted), go to HALT.
  - Otherwise hold imem_req=1 until imem_ready.
  - On imem_ready: ir_write=1 in that cycle, then go to DECODE.
- DECODE: latch the class.
  - 00100 OP_IMM, 01100 OP, 00000 LOAD, 01000 STORE, 11000 BRANCH, 11011 JAL, 01101 LUI.
  - Any other opcode: illegal=1, pc_write=1, pc_src=00, go to FETCH. Not counted in instret.
- EXEC: opcode_alu and imm_data are valid here and held through WB.
  - OP: 11, imm_data=0.
  - OP_IMM and LUI: 01, imm_data=1.
  - LOAD and STORE: 10, imm_data=1.
  - BRANCH: 00, imm_data=0.
  - JAL: 10, imm_data=1.
  - OP/OP_IMM/LUI/JAL go to WB. LOAD/STORE go to MEM.
  - BRANCH: pc_write=1, pc_src=01 if branch_taken else 00; retire; go to FETCH.
- MEM: hold dmem_req=1, with dmem_we=1 for STORE, until dmem_ready.
  - LOAD then goes to WB.
  - STORE: pc_write=1, pc_src=00 in the dmem_ready cycle; retire; go to FETCH.
- WB: reg_write=1, mem_to_reg=1 only for LOAD, pc_write=1, pc_src=10 for JAL else 00; retire; go to FETCH.
- Retire: instret increments by 1 on the retiring cycle and wraps at 2^CNT_W-1 -> 0.
- Timeout: a wait counter clears on entering FETCH/MEM and counts cycles with req=1 and ready=0.
  - When it reaches TIMEOUT, set bus_err=1 (sticky until reset), drop req, go to HALT.
  - Ready arriving in the same cycle the count reaches TIMEOUT counts as success.
- HALT: all enables 0, halted=1.
  - If bus_err=0 and halt_req=0, go to FETCH next cycle.
  - If bus_err=1, stay in HALT until reset.
- halt_req asserted in any state other than FETCH is honoured at the next FETCH entry. An in-flight instruction always completes.
- Cycle counts with zero-wait memories:
  - OP/OP_IMM/LUI/JAL: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.

Test Plan:
- Reset release, imem_ready=1, opcode=0110011 -> IDLE, FETCH(ir_write), DECODE, EXEC(opcode_alu=11), WB(reg_write=1, pc_write=1, pc_src=00); instret=1 after 5 clk.
- LOAD 0000011 with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0; WB has mem_to_reg=1; total 8 cycles.
- BRANCH 1100011, branch_taken=1 then 0 -> pc_src=01 then 00 in EXEC, reg_write never 1; each takes 3 cycles.
- opcode=1111111 -> illegal pulse 1 cycle in DECODE, pc_write=1, instret unchanged.
- imem_ready held 0 with TIMEOUT=16 -> bus_err=1 after 16 wait cycles, halted=1, imem_req=0; stays halted until rst_n=0.
- halt_req=1 during EXEC of STORE -> store completes (dmem_we=1), then HALT; drop halt_req -> FETCH next cycle; assert rst_n=0 in MEM -> dmem_req=0 immediately.
